// File: rtl/nts_rx_packet_buffer.sv
// nts_rx_packet_buffer
// Receive-side packet store for the NTS engine. Copies one packet from a
// first-word-fall-through dispatch FIFO into a 2^ADDR_WIDTH x 64-bit RAM,
// then serves big-endian byte-addressed reads of 1, 2, 4 or 8 bytes
// (aligned or unaligned) through a wait/rd_en/rd_dv access port.
// Optional feature macro: NTS_RX_BUFFER_OVERFLOW_EN enables the sticky
// o_overflow flag; without it o_overflow is tied low.
module nts_rx_packet_buffer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_areset,
    input  logic                    i_clear,
    input  logic                    i_dispatch_packet_available,
    input  logic                    i_dispatch_fifo_empty,
    output logic                    o_dispatch_fifo_rd_en,
    input  logic [63:0]             i_dispatch_fifo_rd_data,
    output logic                    o_access_port_wait,
    input  logic [ADDR_WIDTH+2:0]   i_access_port_addr,
    input  logic [2:0]              i_access_port_wordsize,
    input  logic                    i_access_port_rd_en,
    output logic                    o_access_port_rd_dv,
    output logic [63:0]             o_access_port_rd_data,
    output logic                    o_overflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        COPY,
        READY,
        RD1,
        RD2,
        OUT
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    // Write pointer; it saturates at DEPTH and therefore doubles as the
    // count of valid words held in the RAM.
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic                  w_ram_full;
    logic                  w_write_en;

    logic [63:0]           r_mem [0:DEPTH-1];
    logic [63:0]           r_ram_rdata;
    logic [ADDR_WIDTH-1:0] w_rd_word;

    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [2:0]            r_offset;
    logic [2:0]            r_wordsize;
    logic [63:0]           r_first_word;

    logic [ADDR_WIDTH:0]   w_second_idx;
    logic                  w_first_valid;
    logic                  w_second_valid;
    logic [3:0]            w_nbytes;
    logic                  w_span;
    logic                  w_finish;
    logic                  w_accept;
    logic [63:0]           w_hi;
    logic [63:0]           w_lo;
    logic [127:0]          w_pair;
    logic [127:0]          w_shifted;
    logic [63:0]           w_top;
    logic [63:0]           w_result;

    assign w_ram_full = r_wr_ptr[ADDR_WIDTH];
    assign w_write_en = o_dispatch_fifo_rd_en & ~w_ram_full & ~i_clear;
    assign w_accept   = (r_state == READY) & i_access_port_rd_en & ~i_clear;

    // State register with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; clear overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        if (i_clear) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
                        w_next_state = COPY;
                    end
                end
                COPY: begin
                    if (i_dispatch_fifo_empty) begin
                        w_next_state = READY;
                    end
                end
                READY: begin
                    if (i_access_port_rd_en) begin
                        w_next_state = RD1;
                    end
                end
                RD1: begin
                    w_next_state = w_span ? RD2 : OUT;
                end
                RD2: begin
                    w_next_state = OUT;
                end
                OUT: begin
                    w_next_state = READY;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs: FIFO pop strobe and access-port wait.
    always_comb begin
        o_dispatch_fifo_rd_en = (r_state == COPY) && !i_dispatch_fifo_empty;
        o_access_port_wait    = (r_state != READY);
    end

    // Write pointer: advances on every stored word, stops at RAM full.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_wr_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
        end else if (o_dispatch_fifo_rd_en && !w_ram_full) begin
            r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH + 1)'(1);
        end
    end

    // RAM write port; words popped while full are simply not written.
    always_ff @(posedge i_clk) begin
        if (w_write_en) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_dispatch_fifo_rd_data;
        end
    end

    // The read address is the requested word while waiting for a request,
    // and the following word during RD1 for requests spanning two words.
    assign w_rd_word = (r_state == RD1) ? (r_word_idx + ADDR_WIDTH'(1))
                                        : i_access_port_addr[ADDR_WIDTH+2:3];

    // Synchronous RAM read port.
    always_ff @(posedge i_clk) begin
        r_ram_rdata <= r_mem[w_rd_word];
    end

    // Latch request fields on accept and hold the first word across RD2.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_word_idx   <= '0;
            r_offset     <= '0;
            r_wordsize   <= '0;
            r_first_word <= '0;
        end else begin
            if (w_accept) begin
                r_word_idx <= i_access_port_addr[ADDR_WIDTH+2:3];
                r_offset   <= i_access_port_addr[2:0];
                r_wordsize <= i_access_port_wordsize;
            end
            if (r_state == RD1) begin
                r_first_word <= w_first_valid ? r_ram_rdata : 64'd0;
            end
        end
    end

    // Words at or above the stored count read as zero; the second word
    // index is one bit wider so that running off the RAM end is also zero.
    assign w_second_idx   = {1'b0, r_word_idx} + (ADDR_WIDTH + 1)'(1);
    assign w_first_valid  = ({1'b0, r_word_idx} < r_wr_ptr);
    assign w_second_valid = (w_second_idx < r_wr_ptr);

    // Decode wordsize into a byte count; illegal sizes give zero bytes.
    always_comb begin
        case (r_wordsize)
            3'd0:    w_nbytes = 4'd1;
            3'd1:    w_nbytes = 4'd2;
            3'd2:    w_nbytes = 4'd4;
            3'd3:    w_nbytes = 4'd8;
            default: w_nbytes = 4'd0;
        endcase
    end

    assign w_span   = (w_nbytes != 4'd0) && (({1'b0, r_offset} + w_nbytes) > 4'd8);
    assign w_finish = ((r_state == RD1) && !w_span) || (r_state == RD2);

    // Byte extraction: the two candidate words form a 128-bit big-endian
    // window, the offset shifts the first wanted byte to the top, and the
    // top N bytes are then right-aligned.
    always_comb begin
        w_hi = 64'd0;
        w_lo = 64'd0;
        if (r_state == RD1) begin
            w_hi = w_first_valid ? r_ram_rdata : 64'd0;
        end else begin
            w_hi = r_first_word;
        end
        if ((r_state == RD2) && w_second_valid) begin
            w_lo = r_ram_rdata;
        end
        w_pair    = {w_hi, w_lo};
        w_shifted = w_pair << {r_offset, 3'b000};
        w_top     = w_shifted[127:64];
        if (w_nbytes == 4'd0) begin
            w_result = 64'd0;
        end else begin
            w_result = w_top >> (7'd64 - {w_nbytes, 3'b000});
        end
    end

    // Read-data-valid pulse and held read data; clear drops dv only.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_access_port_rd_dv   <= 1'b0;
            o_access_port_rd_data <= 64'd0;
        end else if (i_clear) begin
            o_access_port_rd_dv   <= 1'b0;
        end else begin
            o_access_port_rd_dv <= w_finish;
            if (w_finish) begin
                o_access_port_rd_data <= w_result;
            end
        end
    end

`ifdef NTS_RX_BUFFER_OVERFLOW_EN
    // Sticky overflow flag: set by any pop attempted while the RAM is full.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            o_overflow <= 1'b0;
        end else if (o_dispatch_fifo_rd_en && w_ram_full) begin
            o_overflow <= 1'b1;
        end
    end
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_nts_rx_packet_buffer.sv
// Testbench for nts_rx_packet_buffer: directed scenarios against a default
// instance (ADDR_WIDTH=10) and a small instance (ADDR_WIDTH=2) for overflow.
module tb_nts_rx_packet_buffer;

    logic        clk = 1'b0;
    logic        areset;
    logic        clear;
    logic [12:0] accAddr;
    logic [2:0]  accSize;
    logic        accRdEn;

    logic        availA, emptyA, rdEnA, waitA, dvA, ovfA;
    logic [63:0] fifoDataA, rdDataA;
    logic        availB, emptyB, rdEnB, waitB, dvB, ovfB;
    logic [63:0] fifoDataB, rdDataB;

    logic [63:0] qA[$];
    logic [63:0] qB[$];
    int          popCountA;
    int          popCountB;
    int          testsRun;
    int          testsFailed;
    bit          expOvf;

    always #5 clk = ~clk;

    nts_rx_packet_buffer #(.ADDR_WIDTH(10)) dutA (
        .i_clk(clk), .i_areset(areset), .i_clear(clear),
        .i_dispatch_packet_available(availA),
        .i_dispatch_fifo_empty(emptyA),
        .o_dispatch_fifo_rd_en(rdEnA),
        .i_dispatch_fifo_rd_data(fifoDataA),
        .o_access_port_wait(waitA),
        .i_access_port_addr(accAddr),
        .i_access_port_wordsize(accSize),
        .i_access_port_rd_en(accRdEn),
        .o_access_port_rd_dv(dvA),
        .o_access_port_rd_data(rdDataA),
        .o_overflow(ovfA)
    );

    nts_rx_packet_buffer #(.ADDR_WIDTH(2)) dutB (
        .i_clk(clk), .i_areset(areset), .i_clear(clear),
        .i_dispatch_packet_available(availB),
        .i_dispatch_fifo_empty(emptyB),
        .o_dispatch_fifo_rd_en(rdEnB),
        .i_dispatch_fifo_rd_data(fifoDataB),
        .o_access_port_wait(waitB),
        .i_access_port_addr(accAddr[4:0]),
        .i_access_port_wordsize(accSize),
        .i_access_port_rd_en(accRdEn),
        .o_access_port_rd_dv(dvB),
        .o_access_port_rd_data(rdDataB),
        .o_overflow(ovfB)
    );

    // FIFO heads follow the bench queues (first-word-fall-through).
    task automatic refreshFifo();
        emptyA    = (qA.size() == 0);
        fifoDataA = emptyA ? 64'd0 : qA[0];
        emptyB    = (qB.size() == 0);
        fifoDataB = emptyB ? 64'd0 : qB[0];
    endtask

    // Advance one clock; pops are decided from rd_en sampled mid-cycle,
    // and the task returns 1 time unit after the rising edge.
    task automatic tick();
        bit popA;
        bit popB;
        logic [63:0] tmp;
        @(negedge clk);
        popA = rdEnA;
        popB = rdEnB;
        @(posedge clk);
        #1;
        if (popA && qA.size() > 0) begin tmp = qA.pop_front(); popCountA++; end
        if (popB && qB.size() > 0) begin tmp = qB.pop_front(); popCountB++; end
        refreshFifo();
    endtask

    // Issue one read request and wait (bounded) for dv. lat counts cycles
    // from the accept cycle T to the dv cycle, -1 on timeout; waitOk is
    // cleared if wait dropped between the accept and the dv cycle.
    task automatic issueRead(input logic [12:0] addr, input logic [2:0] size, input bit useB,
                             output logic [63:0] data, output int lat, output bit waitOk);
        accAddr = addr;
        accSize = size;
        accRdEn = 1'b1;
        lat     = -1;
        waitOk  = 1'b1;
        data    = 64'd0;
        tick();
        accRdEn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if ((useB ? waitB : waitA) !== 1'b1) waitOk = 1'b0;
            if ((useB ? dvB : dvA) === 1'b1) begin
                lat  = k;
                data = useB ? rdDataB : rdDataA;
                break;
            end
            tick();
        end
    endtask

    // Run a copy until the instance leaves wait (bounded); returns success.
    task automatic waitReady(input bit useB, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if ((useB ? waitB : waitA) === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick(); tick();
        areset = 1'b0;
        tick();
        testsRun++; if (waitA !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_wait got=%b exp=1", waitA); end
        testsRun++; if (dvA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_dv got=%b exp=0", dvA); end
        testsRun++; if (rdDataA !== 64'd0) begin testsFailed++; $display("[TB] FAIL reset_data got=%h exp=0", rdDataA); end
        testsRun++; if (ovfA !== 1'b0 || ovfB !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overflow got=%b%b exp=00", ovfA, ovfB); end
        testsRun++; if (rdEnA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_fifo_rd_en got=%b exp=0", rdEnA); end
    endtask

    task automatic test_copy();
        bit ok;
        qA.push_back(64'h0001020304050607);
        qA.push_back(64'h08090A0B0C0D0E0F);
        qA.push_back(64'h1011121314151617);
        refreshFifo();
        popCountA = 0;
        availA = 1'b1;
        waitReady(1'b0, ok);
        availA = 1'b0;
        testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL copy_ready got=%b exp=1", ok); end
        testsRun++; if (popCountA != 3) begin testsFailed++; $display("[TB] FAIL copy_pops got=%0d exp=3", popCountA); end
    endtask

    task automatic test_aligned_read();
        logic [63:0] d; int lat; bit wok;
        issueRead(13'd0, 3'd3, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2) begin testsFailed++; $display("[TB] FAIL aligned_lat got=%0d exp=2", lat); end
        testsRun++; if (d !== 64'h0001020304050607) begin testsFailed++; $display("[TB] FAIL aligned_data got=%h exp=0001020304050607", d); end
        testsRun++; if (wok !== 1'b1) begin testsFailed++; $display("[TB] FAIL aligned_wait got=%b exp=1", wok); end
        tick();
        testsRun++; if (dvA !== 1'b0 || waitA !== 1'b0) begin testsFailed++; $display("[TB] FAIL aligned_after dv=%b wait=%b exp=0,0", dvA, waitA); end
    endtask

    task automatic test_cross_word();
        logic [63:0] d; int lat; bit wok;
        issueRead(13'd7, 3'd1, 1'b0, d, lat, wok);
        testsRun++; if (lat != 3) begin testsFailed++; $display("[TB] FAIL cross_lat got=%0d exp=3", lat); end
        testsRun++; if (d !== 64'h0708) begin testsFailed++; $display("[TB] FAIL cross_data got=%h exp=0708", d); end
        testsRun++; if (wok !== 1'b1) begin testsFailed++; $display("[TB] FAIL cross_wait got=%b exp=1", wok); end
        tick();
        testsRun++; if (waitA !== 1'b0) begin testsFailed++; $display("[TB] FAIL cross_ready got=%b exp=0", waitA); end
    endtask

    task automatic test_unaligned();
        logic [63:0] d; int lat; bit wok;
        issueRead(13'd2, 3'd2, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'h02030405) begin testsFailed++; $display("[TB] FAIL unal_a2 got=%h lat=%0d exp=02030405 lat=2", d, lat); end
        tick();
        issueRead(13'd20, 3'd2, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'h14151617) begin testsFailed++; $display("[TB] FAIL unal_a20 got=%h lat=%0d exp=14151617 lat=2", d, lat); end
        tick();
        issueRead(13'd22, 3'd1, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'h1617) begin testsFailed++; $display("[TB] FAIL unal_a22 got=%h lat=%0d exp=1617 lat=2", d, lat); end
        tick();
    endtask

    task automatic test_unwritten();
        logic [63:0] d; int lat; bit wok;
        issueRead(13'd24, 3'd0, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'd0) begin testsFailed++; $display("[TB] FAIL unwr_a24 got=%h lat=%0d exp=0 lat=2", d, lat); end
        tick();
        issueRead(13'd21, 3'd3, 1'b0, d, lat, wok);
        testsRun++; if (lat != 3 || d !== 64'h1516170000000000) begin testsFailed++; $display("[TB] FAIL unwr_a21 got=%h lat=%0d exp=1516170000000000 lat=3", d, lat); end
        tick();
    endtask

    task automatic test_illegal_size();
        logic [63:0] d; int lat; bit wok;
        issueRead(13'd0, 3'd5, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'd0) begin testsFailed++; $display("[TB] FAIL illegal_size got=%h lat=%0d exp=0 lat=2", d, lat); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; int lat; bit wok;
        issueRead(13'd8, 3'd0, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'h08) begin testsFailed++; $display("[TB] FAIL b2b_first got=%h lat=%0d exp=08 lat=2", d, lat); end
        tick();
        issueRead(13'd15, 3'd0, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'h0F) begin testsFailed++; $display("[TB] FAIL b2b_second got=%h lat=%0d exp=0f lat=2", d, lat); end
        tick(); tick(); tick();
        testsRun++; if (dvA !== 1'b0 || rdDataA !== 64'h0F) begin testsFailed++; $display("[TB] FAIL b2b_hold dv=%b data=%h exp=0,0f", dvA, rdDataA); end
    endtask

    task automatic test_clear();
        logic [63:0] d; int lat; bit wok; bit ok; int dvSeen;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        testsRun++; if (waitA !== 1'b1) begin testsFailed++; $display("[TB] FAIL clear_ready_wait got=%b exp=1", waitA); end
        qA.push_back(64'hC0C1C2C3C4C5C6C7);
        qA.push_back(64'hC8C9CACBCCCDCECF);
        qA.push_back(64'hD0D1D2D3D4D5D6D7);
        refreshFifo();
        availA = 1'b1;
        tick();
        testsRun++; if (rdEnA !== 1'b1) begin testsFailed++; $display("[TB] FAIL clear_copy_rd_en got=%b exp=1", rdEnA); end
        tick();
        clear  = 1'b1;
        availA = 1'b0;
        tick();
        clear = 1'b0;
        testsRun++; if (rdEnA !== 1'b0 || waitA !== 1'b1) begin testsFailed++; $display("[TB] FAIL clear_mid_copy rd_en=%b wait=%b exp=0,1", rdEnA, waitA); end
        dvSeen  = 0;
        accAddr = 13'd0;
        accSize = 3'd3;
        accRdEn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (dvA === 1'b1) dvSeen++;
        end
        accRdEn = 1'b0;
        testsRun++; if (dvSeen != 0) begin testsFailed++; $display("[TB] FAIL idle_no_dv got=%0d exp=0", dvSeen); end
        testsRun++; if (rdDataA !== 64'h0F) begin testsFailed++; $display("[TB] FAIL clear_keeps_data got=%h exp=0f", rdDataA); end
        qA.delete();
        qA.push_back(64'hA0A1A2A3A4A5A6A7);
        refreshFifo();
        availA = 1'b1;
        waitReady(1'b0, ok);
        availA = 1'b0;
        testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL recopy_ready got=%b exp=1", ok); end
        issueRead(13'd0, 3'd3, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'hA0A1A2A3A4A5A6A7) begin testsFailed++; $display("[TB] FAIL recopy_w0 got=%h lat=%0d exp=a0a1a2a3a4a5a6a7 lat=2", d, lat); end
        tick();
        issueRead(13'd8, 3'd0, 1'b0, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'd0) begin testsFailed++; $display("[TB] FAIL recopy_w1_zero got=%h lat=%0d exp=0 lat=2", d, lat); end
        tick();
    endtask

    task automatic test_overflow();
        logic [63:0] d; int lat; bit wok; bit ok;
        qB.push_back(64'h0011223344556677);
        qB.push_back(64'h8899AABBCCDDEEFF);
        qB.push_back(64'h0102030405060708);
        qB.push_back(64'h1122334455667788);
        qB.push_back(64'hDEADBEEFCAFEF00D);
        refreshFifo();
        popCountB = 0;
        availB = 1'b1;
        waitReady(1'b1, ok);
        availB = 1'b0;
        testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_ready got=%b exp=1", ok); end
        testsRun++; if (popCountB != 5) begin testsFailed++; $display("[TB] FAIL ovf_pops got=%0d exp=5", popCountB); end
        testsRun++; if (ovfB !== expOvf) begin testsFailed++; $display("[TB] FAIL ovf_flag got=%b exp=%b", ovfB, expOvf); end
        issueRead(13'd0, 3'd3, 1'b1, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'h0011223344556677) begin testsFailed++; $display("[TB] FAIL ovf_w0 got=%h lat=%0d exp=0011223344556677 lat=2", d, lat); end
        tick();
        issueRead(13'd24, 3'd3, 1'b1, d, lat, wok);
        testsRun++; if (lat != 2 || d !== 64'h1122334455667788) begin testsFailed++; $display("[TB] FAIL ovf_w3 got=%h lat=%0d exp=1122334455667788 lat=2", d, lat); end
        tick();
        issueRead(13'd28, 3'd3, 1'b1, d, lat, wok);
        testsRun++; if (lat != 3 || d !== 64'h5566778800000000) begin testsFailed++; $display("[TB] FAIL ovf_ram_end got=%h lat=%0d exp=5566778800000000 lat=3", d, lat); end
        tick();
        testsRun++; if (ovfB !== expOvf) begin testsFailed++; $display("[TB] FAIL ovf_sticky got=%b exp=%b", ovfB, expOvf); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        testsRun++; if (ovfB !== 1'b0 || waitB !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_clear ovf=%b wait=%b exp=0,1", ovfB, waitB); end
    endtask

    // Watchdog so the run always ends even if the DUT stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef NTS_RX_BUFFER_OVERFLOW_EN
        expOvf = 1'b1;
`else
        expOvf = 1'b0;
`endif
        testsRun    = 0;
        testsFailed = 0;
        popCountA   = 0;
        popCountB   = 0;
        areset  = 1'b1;
        clear   = 1'b0;
        availA  = 1'b0;
        availB  = 1'b0;
        accAddr = '0;
        accSize = '0;
        accRdEn = 1'b0;
        refreshFifo();
        test_reset();
        test_copy();
        test_aligned_read();
        test_cross_word();
        test_unaligned();
        test_unwritten();
        test_illegal_size();
        test_back_to_back();
        test_clear();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
